alu16: RTL and testbench

- 16-bit integer ALU for the datapath of the CR16-style processor.
- Executes one of 23 register/immediate operations selected by a 5-bit OpCode.
- Registers the result and a 5-bit processor-status flag word.
- Immediate operands arrive already extended on Rsrc; the ALU does not distinguish immediate forms except where noted.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu16_comb.sv | 121 ++++++++++++
 rtl/alu16.sv | 47 ++++
 tb/tb_alu16.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu16 datapath ALU: operation codes and
// status-flag bit positions, plus a small overflow helper.
package alu_pkg;

  localparam int OP_W   = 5;
  localparam int FLAG_W = 5;

  // Status flag bit positions within Flags
  localparam int FLAG_C = 0;  // carry / borrow
  localparam int FLAG_L = 1;  // unsigned less-than
  localparam int FLAG_F = 2;  // signed overflow
  localparam int FLAG_Z = 3;  // zero
  localparam int FLAG_N = 4;  // negative / signed less-than

  // Operation codes
  localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADDI   = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADDU   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDUI  = 5'b00011;
  localparam logic [OP_W-1:0] OP_ADDC   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDCU  = 5'b00101;
  localparam logic [OP_W-1:0] OP_ADDCUI = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDCI  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SUB    = 5'b01000;
  localparam logic [OP_W-1:0] OP_SUBI   = 5'b01001;
  localparam logic [OP_W-1:0] OP_CMP    = 5'b01010;
  localparam logic [OP_W-1:0] OP_CMPI   = 5'b01011;
  localparam logic [OP_W-1:0] OP_CMPUI  = 5'b01100;
  localparam logic [OP_W-1:0] OP_AND    = 5'b01101;
  localparam logic [OP_W-1:0] OP_OR     = 5'b01110;
  localparam logic [OP_W-1:0] OP_XOR    = 5'b01111;
  localparam logic [OP_W-1:0] OP_NOT    = 5'b10000;
  localparam logic [OP_W-1:0] OP_LSH    = 5'b10001;
  localparam logic [OP_W-1:0] OP_LSHI   = 5'b10010;
  localparam logic [OP_W-1:0] OP_RSH    = 5'b10011;
  localparam logic [OP_W-1:0] OP_RSHI   = 5'b10100;
  localparam logic [OP_W-1:0] OP_ALSH   = 5'b10101;
  localparam logic [OP_W-1:0] OP_ARSH   = 5'b10110;

  // Two's-complement overflow: operands agree in sign, result does not.
  // Callers pass the effective second operand sign (inverted for subtract).
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu16_comb.sv
// Combinational core of alu16: computes the result word and the next
// value of the status flags from the operands, opcode and current flags.
module alu16_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  rdest,
  input  logic [WIDTH-1:0]  rsrc,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FLAG_W-1:0] flags_q,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags_d
);

  logic               use_cin;
  logic               cin;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic               add_ovf;
  logic               sub_ovf;
  logic [3:0]         shamt;
  logic signed [WIDTH-1:0] rdest_s;
  logic signed [WIDTH-1:0] rsrc_s;
  logic signed [WIDTH-1:0] arsh_res;

  // Carry chain only consumes the stored C flag for the ADDC family
  assign use_cin = (opcode == OP_ADDC)  || (opcode == OP_ADDCI) ||
                   (opcode == OP_ADDCU) || (opcode == OP_ADDCUI);
  assign cin     = use_cin & flags_q[FLAG_C];

  // One extra bit on the adder/subtractor captures carry-out and borrow
  assign add_ext = {1'b0, rdest} + {1'b0, rsrc} + {{WIDTH{1'b0}}, cin};
  assign sub_ext = {1'b0, rdest} - {1'b0, rsrc};
  assign add_res = add_ext[WIDTH-1:0];
  assign sub_res = sub_ext[WIDTH-1:0];
  assign add_ovf = signed_ovf(rdest[WIDTH-1], rsrc[WIDTH-1], add_res[WIDTH-1]);
  assign sub_ovf = signed_ovf(rdest[WIDTH-1], ~rsrc[WIDTH-1], sub_res[WIDTH-1]);

  // Shifts honour only the low nibble, so 17 behaves like 1
  assign shamt    = rsrc[3:0];
  assign rdest_s  = rdest;
  assign rsrc_s   = rsrc;
  assign arsh_res = rdest_s >>> shamt;

  // Select result and update only the flags each operation owns
  always_comb begin
    result  = '0;
    flags_d = flags_q;
    case (opcode)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
        result          = add_res;
        flags_d[FLAG_C] = add_ext[WIDTH];
        flags_d[FLAG_F] = add_ovf;
        flags_d[FLAG_Z] = ~|add_res;
        flags_d[FLAG_N] = add_res[WIDTH-1];
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        result          = add_res;
        flags_d[FLAG_C] = add_ext[WIDTH];
      end
      OP_SUB, OP_SUBI: begin
        result          = sub_res;
        flags_d[FLAG_C] = sub_ext[WIDTH];
        flags_d[FLAG_F] = sub_ovf;
        flags_d[FLAG_Z] = ~|sub_res;
        flags_d[FLAG_N] = sub_res[WIDTH-1];
      end
      OP_CMP, OP_CMPI, OP_CMPUI: begin
        // Compare passes Rdest through; flags describe the relation
        result          = rdest;
        flags_d[FLAG_Z] = (rdest == rsrc);
        flags_d[FLAG_N] = (rdest_s < rsrc_s);
        flags_d[FLAG_L] = (rdest < rsrc);
      end
      OP_AND: begin
        result          = rdest & rsrc;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_OR: begin
        result          = rdest | rsrc;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_XOR: begin
        result          = rdest ^ rsrc;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_NOT: begin
        result          = ~rsrc;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_LSH, OP_LSHI, OP_ALSH: begin
        result          = rdest << shamt;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_RSH, OP_RSHI: begin
        result          = rdest >> shamt;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      OP_ARSH: begin
        result          = arsh_res;
        flags_d[FLAG_Z] = ~|result;
        flags_d[FLAG_N] = result[WIDTH-1];
      end
      default: begin
        // Unassigned opcodes produce zero and leave status untouched
        result  = '0;
        flags_d = flags_q;
      end
    endcase
  end

endmodule

// File: rtl/alu16.sv
// alu16 top: registers the combinational ALU result and status flags.
// Single-cycle latency, one operation accepted every clock.
module alu16
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  Rsrc,
  input  logic [WIDTH-1:0]  Rdest,
  input  logic [OP_W-1:0]   OpCode,
  output logic [WIDTH-1:0]  Out,
  output logic [FLAG_W-1:0] Flags
);

  logic [WIDTH-1:0]  out_d;
  logic [WIDTH-1:0]  out_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;

  alu16_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .rdest   (Rdest),
    .rsrc    (Rsrc),
    .opcode  (OpCode),
    .flags_q (flags_q),
    .result  (out_d),
    .flags_d (flags_d)
  );

  // Result and status registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign Out   = out_q;
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu16.sv
// Directed self-checking bench for alu16. Flags are written as the 5-bit
// word {N,Z,F,L,C}.
module tb_alu16;

  logic        clk;
  logic        reset_n;
  logic [15:0] Rsrc;
  logic [15:0] Rdest;
  logic [4:0]  OpCode;
  logic [15:0] Out;
  logic [4:0]  Flags;

  int tests;
  int fails;

  alu16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Rsrc    (Rsrc),
    .Rdest   (Rdest),
    .OpCode  (OpCode),
    .Out     (Out),
    .Flags   (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation away from the active edge and wait for its result
  task automatic do_op(input logic [4:0] op, input logic [15:0] d,
                       input logic [15:0] s);
    @(negedge clk);
    OpCode = op;
    Rdest  = d;
    Rsrc   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    Rsrc    = 16'h0000;
    Rdest   = 16'h0000;
    OpCode  = 5'b00000;
    #12;
    check("reset_out", Out, 16'h0000);
    check("reset_flags", {11'd0, Flags}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(5'b00000, 16'd2, 16'd3);
    check("add_2_3_out", Out, 16'h0005);
    check("add_2_3_flags", {11'd0, Flags}, 16'h0000);

    do_op(5'b00000, 16'hFFFF, 16'h0001);
    check("add_wrap_out", Out, 16'h0000);
    check("add_wrap_flags", {11'd0, Flags}, 16'h0009);

    do_op(5'b00000, 16'h7FFF, 16'h0001);
    check("add_ovf_out", Out, 16'h8000);
    check("add_ovf_flags", {11'd0, Flags}, 16'h0014);

    // Asynchronous reset in the middle of an operation, no clock edge
    @(negedge clk);
    OpCode = 5'b00000;
    Rdest  = 16'hFFFF;
    Rsrc   = 16'hFFFF;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", Out, 16'h0000);
    check("async_rst_flags", {11'd0, Flags}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_out", Out, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(5'b00000, 16'd2, 16'd3);
    check("post_rst_add_out", Out, 16'h0005);

    do_op(5'b01101, 16'hFFFF, 16'hFFFF);
    check("and_out", Out, 16'hFFFF);
    check("and_flags", {11'd0, Flags}, 16'h0010);

    do_op(5'b01111, 16'hFFFF, 16'hFFFF);
    check("xor_out", Out, 16'h0000);
    check("xor_flags", {11'd0, Flags}, 16'h0008);

    do_op(5'b00000, 16'hFFFF, 16'h0001);
    check("carry_set_flags", {11'd0, Flags}, 16'h0009);
    do_op(5'b00100, 16'h0000, 16'h0000);
    check("addc_out", Out, 16'h0001);
    check("addc_flags", {11'd0, Flags}, 16'h0000);

    do_op(5'b00000, 16'hFFFF, 16'h0001);
    do_op(5'b00101, 16'h0001, 16'h0001);
    check("addcu_out", Out, 16'h0003);
    check("addcu_flags", {11'd0, Flags}, 16'h0008);

    do_op(5'b00010, 16'h8000, 16'h8000);
    check("addu_out", Out, 16'h0000);
    check("addu_flags", {11'd0, Flags}, 16'h0009);

    do_op(5'b01000, 16'd3, 16'd5);
    check("sub_borrow_out", Out, 16'hFFFE);
    check("sub_borrow_flags", {11'd0, Flags}, 16'h0011);

    do_op(5'b01000, 16'h8000, 16'h0001);
    check("sub_ovf_out", Out, 16'h7FFF);
    check("sub_ovf_flags", {11'd0, Flags}, 16'h0004);

    do_op(5'b01010, 16'hFFFF, 16'h0001);
    check("cmp_neg_out", Out, 16'hFFFF);
    check("cmp_neg_flags", {11'd0, Flags}, 16'h0014);

    do_op(5'b01010, 16'd3, 16'd3);
    check("cmp_eq_out", Out, 16'h0003);
    check("cmp_eq_flags", {11'd0, Flags}, 16'h000C);

    do_op(5'b01010, 16'h0001, 16'hFFFF);
    check("cmp_ult_flags", {11'd0, Flags}, 16'h0006);

    do_op(5'b10000, 16'h1234, 16'h00FF);
    check("not_out", Out, 16'hFF00);
    check("not_flags", {11'd0, Flags}, 16'h0016);

    do_op(5'b10001, 16'h8001, 16'd1);
    check("lsh1_out", Out, 16'h0002);
    check("lsh1_flags", {11'd0, Flags}, 16'h0006);

    do_op(5'b10011, 16'h8001, 16'd4);
    check("rsh4_out", Out, 16'h0800);

    do_op(5'b10110, 16'h8001, 16'd4);
    check("arsh4_out", Out, 16'hF800);
    check("arsh4_flags", {11'd0, Flags}, 16'h0016);

    do_op(5'b10001, 16'h8001, 16'd17);
    check("lsh17_out", Out, 16'h0002);

    do_op(5'b01110, 16'h0F00, 16'h00F0);
    check("or_out", Out, 16'h0FF0);
    check("or_flags", {11'd0, Flags}, 16'h0006);

    do_op(5'b11111, 16'h1234, 16'h5678);
    check("unused_out", Out, 16'h0000);
    check("unused_flags", {11'd0, Flags}, 16'h0006);

    do_op(5'b10111, 16'hFFFF, 16'hFFFF);
    check("unused2_out", Out, 16'h0000);

    do_op(5'b00001, 16'h0010, 16'h0020);
    check("addi_out", Out, 16'h0030);
    check("addi_flags", {11'd0, Flags}, 16'h0002);

    do_op(5'b01001, 16'h0000, 16'h0000);
    check("subi_zero_out", Out, 16'h0000);
    check("subi_zero_flags", {11'd0, Flags}, 16'h000A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
